// File: rtl/preif_stage_pkg.sv
// Shared constants and helpers for the pre-fetch stage.
package preif_stage_pkg;

  localparam int unsigned TO_IF_DATA_WIDTH = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h1c000000;

  typedef logic [31:0] pc_t;

  function automatic pc_t seq_pc(input pc_t pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/preif_stage_redirect_buf.sv
// Holds a branch redirect that arrived while IF could not accept a new PC.
module preif_redirect_buf
  import preif_stage_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        fire,
  input  logic        csr_reset,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        br_pend,
  output logic [31:0] br_pend_target
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      br_pend        <= 1'b0;
      br_pend_target <= '0;
    end else if (fire || csr_reset) begin
      br_pend <= 1'b0;
    end else if (br_taken && !br_pend) begin
      // first redirect wins; later ones are on the wrong path
      br_pend        <= 1'b1;
      br_pend_target <= br_target;
    end
  end

endmodule

// File: rtl/preif_stage.sv
// Pre-fetch stage: next-PC selection, inst_sram read issue and IF handshake.
module preif_stage
  import preif_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        br_taken,
  input  logic [31:0]                 br_target,
  input  logic                        csr_reset,
  input  logic [31:0]                 csr_target,
  input  logic                        IF_allow_in,
  output logic                        preIF_to_IF_valid,
  output logic [TO_IF_DATA_WIDTH-1:0] to_IF_data,
  output logic                        inst_sram_en,
  output logic [3:0]                  inst_sram_we,
  output logic [31:0]                 inst_sram_addr,
  output logic [31:0]                 inst_sram_wdata
);

  logic        preIF_valid_r;
  pc_t         pc_r;
  pc_t         nextpc;
  logic        fire;
  logic        br_pend;
  logic [31:0] br_pend_target;

  assign fire = preIF_valid_r & IF_allow_in;

  preif_redirect_buf u_redirect_buf (
    .clk            (clk),
    .resetn         (resetn),
    .fire           (fire),
    .csr_reset      (csr_reset),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .br_pend        (br_pend),
    .br_pend_target (br_pend_target)
  );

  always_comb begin
    nextpc = seq_pc(pc_r);
    if (csr_reset)     nextpc = csr_target;
    else if (br_pend)  nextpc = br_pend_target;
    else if (br_taken) nextpc = br_target;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      preIF_valid_r <= 1'b0;
      pc_r          <= RESET_PC - 32'd4;
    end else begin
      preIF_valid_r <= 1'b1;
      if (fire) pc_r <= nextpc;
    end
  end

  assign preIF_to_IF_valid = preIF_valid_r;
  assign to_IF_data        = nextpc;
  assign inst_sram_addr    = nextpc;
  // read only on handoff so held SRAM data tracks IF's latched PC
  assign inst_sram_en      = fire;
  assign inst_sram_we      = '0;
  assign inst_sram_wdata   = '0;

endmodule

// File: doc/preif_stage.md
Name: preif_stage

Overview:
- Pre-fetch stage at the head of the pipeline.
- Holds the architectural fetch PC and selects the next PC by priority: CSR redirect (exception or ertn), then buffered branch, then live branch, then sequential.
- Issues the synchronous inst_sram read and hands the PC to IF over the valid/allow_in handshake, so inst_sram_rdata on the following cycle matches IF's latched PC.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
br_taken  in  1  branch/jump redirect pulse from downstream (single cycle)
br_target  in  32  redirect target, qualified by br_taken
csr_reset  in  1  exception/ertn redirect pulse, highest priority
csr_target  in  32  CSR redirect target (entry or era)
IF_allow_in  in  1  IF can accept this cycle (forced 1 by IF while csr_reset)
preIF_to_IF_valid  out  1  preIF holds a valid next PC
to_IF_data  out  `to_IF_data_width  {nextpc} (width 32)
inst_sram_en  out  1  SRAM read enable
inst_sram_we  out  4  write strobes, constant 0
inst_sram_addr  out  32  fetch address
inst_sram_wdata  out  32  constant 0

Behaviour:
- Clock and reset: one clock (clk); resetn asynchronous active-low; all state clears on resetn=0 regardless of clk.
- Reset values:
  - preIF_valid_r=0
  - pc_r=RESET_PC-4
  - br_pend=0, br_pend_target=0
  - so inst_sram_en=0 and preIF_to_IF_valid=0 during reset.
- preIF_valid_r goes to 1 on the first rising edge after resetn deasserts and stays 1. The first fetch is RESET_PC, one cycle after release.
- nextpc (combinational), first match wins:
  1. csr_reset → csr_target
  2. br_pend → br_pend_target
  3. br_taken → br_target
  4. otherwise pc_r+4, mod 2^32; wraps 0xfffffffc → 0x00000000
- Outputs:
  - preIF_to_IF_valid = preIF_valid_r
  - to_IF_data = nextpc
  - inst_sram_addr = nextpc
  - fire = preIF_valid_r & IF_allow_in
  - inst_sram_en = fire. The SRAM is read only on handoff, so its held output stays consistent with IF's latched PC while IF stalls.
- On fire: pc_r<=nextpc, br_pend<=0. Latency to IF: 1 cycle for PC and SRAM data.
- Redirect buffer:
  - br_taken & !fire & !csr_reset & !br_pend: set br_pend=1, latch br_target.
  - br_taken while br_pend=1: ignored; the first redirect wins, and downstream flushes the wrong path.
  - br_taken & fire: live target used directly, nothing buffered.
  - csr_reset: clears br_pend the same edge (IF_allow_in is 1 then, so fire=1); csr_target wins over any branch.
- Alignment: no check here. Misaligned targets pass through unchanged and IF raises ADEF.
- Reset mid-operation: asynchronous clear of all regs, including a pending branch; refetch from RESET_PC.
- No internal FSM beyond the valid bit and the pending-redirect bit. States {IDLE_RESET, RUN, RUN_PEND} are encoded by (preIF_valid_r, br_pend).

Decomposition:
- constants.h: `to_IF_data_width (32), reset PC define (shared with the CSR unit).
- One natural sub-module: preif_redirect_buf, holding the br_pend/br_pend_target registers and the capture/clear logic.
- nextpc mux and handshake stay in preif_stage.

Test Plan:
- Reset release, IF_allow_in=1: first cycle en=1 addr=0x1c000000, then 0x1c000004, 0x1c000008 on consecutive cycles.
- IF_allow_in=0 for 3 cycles at PC 0x1c000008:
  - addr holds 0x1c00000c
  - en=0
  - pc_r unchanged
  - fetch resumes 0x1c00000c.
- br_taken=1, br_target=0x1c000100 while IF_allow_in=0:
  - buffered
  - second br_taken to 0x1c000200 ignored
  - on allow_in, fetch 0x1c000100, then 0x1c000104.
- br_pend set and csr_reset=1, csr_target=0x1c001000 same cycle: fetch 0x1c001000, br_pend cleared, next 0x1c001004.
- br_taken=1, br_target=0x1c000102 with allow_in=1: addr=0x1c000102 passed unaltered; next 0x1c000106.
- resetn pulsed low mid-stall with br_pend=1: outputs drop immediately (en=0, valid=0); after release, fetch restarts at 0x1c000000.
